// File: rtl/alu_result_fifo_pkg.sv
// Shared ALU definitions: operation codes, result-width and pointer-width helpers.
// Imported by the ALU and by alu_result_fifo.
package alu_result_fifo_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OP3 = 2'b11
    } alu_op_e;

    localparam int ALU_OUT_EXTRA = 3;

    function automatic int alu_out_w(input int w);
        return w + ALU_OUT_EXTRA;
    endfunction

    // One extra MSB lets equal low bits distinguish full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// alu_fifo_mem: DEPTH x DW register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module alu_fifo_mem #(
    parameter int DW    = 11,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_CLK,
    input  logic          i_WE,
    input  logic [AW-1:0] i_WADDR,
    input  logic [DW-1:0] i_WDATA,
    input  logic [AW-1:0] i_RADDR,
    output logic [DW-1:0] o_RDATA
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge i_CLK) begin
        if (i_WE) begin
            mem_q[i_WADDR] <= i_WDATA;
        end
    end

    assign o_RDATA = mem_q[i_RADDR];

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO buffering ALU results.
// Optional registered o_ALMOST_FULL output is enabled by defining ALU_FIFO_AFULL_EN.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                        i_CLK,
    input  logic                        i_RSTn,
    input  logic                        i_VALID,
    output logic                        o_READY,
    input  logic [alu_out_w(WIDTH)-1:0] i_DATA,
    output logic                        o_VALID,
    input  logic                        i_READY,
    output logic [alu_out_w(WIDTH)-1:0] o_DATA,
    output logic [ptr_w(DEPTH)-1:0]     o_COUNT
`ifdef ALU_FIFO_AFULL_EN
    ,
    output logic                        o_ALMOST_FULL
`endif
);

    localparam int DW = alu_out_w(WIDTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_result_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("alu_result_fifo: AF_LEVEL must lie in 1..DEPTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] mem_rdata;
    logic          full, empty, push, pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = i_VALID && !full;
    assign pop   = !empty && i_READY;

    alu_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_CLK   (i_CLK),
        .i_WE    (push),
        .i_WADDR (wr_ptr_q[AW-1:0]),
        .i_WDATA (i_DATA),
        .i_RADDR (rd_ptr_d[AW-1:0]),
        .o_RDATA (mem_rdata)
    );

    // o_DATA is registered: it is loaded with the head that will exist after this edge,
    // taking i_DATA directly when the word being written becomes the new head.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        data_d   = data_q;
        if (rd_ptr_d != wr_ptr_d) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                data_d = i_DATA;
            end else begin
                data_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
        end
    end

    assign o_READY = !full;
    assign o_VALID = !empty;
    assign o_DATA  = data_q;
    assign o_COUNT = wr_ptr_q - rd_ptr_q;

`ifdef ALU_FIFO_AFULL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    logic          almost_full_q, almost_full_d;
    logic [PW-1:0] count_d;

    always_comb begin
        count_d       = wr_ptr_d - rd_ptr_d;
        almost_full_d = (count_d >= AF_THRESH);
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign o_ALMOST_FULL = almost_full_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: drivers queue expected words, a monitor
// pops and compares on every consumer handshake and tracks an occupancy model.
module tb_alu_result_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int DW    = WIDTH + 3;
    localparam int PW    = 4;

    logic          clk;
    logic          rst_n;
    logic          i_VALID;
    logic          o_READY;
    logic [DW-1:0] i_DATA;
    logic          o_VALID;
    logic          i_READY;
    logic [DW-1:0] o_DATA;
    logic [PW-1:0] o_COUNT;
`ifdef ALU_FIFO_AFULL_EN
    logic          o_ALMOST_FULL;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb[$];
    int            mcount;
    logic          s_push, s_pop;

    alu_result_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (6)
    ) dut (
        .i_CLK   (clk),
        .i_RSTn  (rst_n),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .i_DATA  (i_DATA),
        .o_VALID (o_VALID),
        .i_READY (i_READY),
        .o_DATA  (o_DATA),
        .o_COUNT (o_COUNT)
`ifdef ALU_FIFO_AFULL_EN
        ,
        .o_ALMOST_FULL (o_ALMOST_FULL)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare popped words against the scoreboard and occupancy against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            s_push <= 1'b0;
            s_pop  <= 1'b0;
        end else begin
            s_push <= i_VALID && o_READY;
            s_pop  <= o_VALID && i_READY;
            chk("count_model", 32'(o_COUNT), 32'(mcount));
            chk("ready_model", 32'(o_READY), 32'(mcount != DEPTH));
            chk("valid_model", 32'(o_VALID), 32'(mcount != 0));
`ifdef ALU_FIFO_AFULL_EN
            chk("almost_full", 32'(o_ALMOST_FULL), 32'(mcount >= 6));
`endif
            if (o_VALID && i_READY) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got %0d expected no word", o_DATA);
                end else begin
                    chk("pop_data", 32'(o_DATA), 32'(sb.pop_front()));
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcount <= 0;
        else        mcount <= mcount + int'(s_push) - int'(s_pop);
    end

    task automatic send(input logic [DW-1:0] d);
        logic r;
        i_VALID = 1'b1;
        i_DATA  = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r = o_READY;
            @(posedge clk);
            if (r) begin
                sb.push_back(d);
                #1;
                i_VALID = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: got no accept expected accept of %0d", d);
        #1;
        i_VALID = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done    = 0;
        i_READY = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (!o_VALID && sb.size() == 0) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: got %0d left expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] burst[5] = '{11'd15, 11'd128, 11'd0, 11'h00A, 11'd3};
    bit prod_done;

    initial begin
        rst_n   = 1'b0;
        i_VALID = 1'b0;
        i_READY = 1'b0;
        i_DATA  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_VALID), 0);
        chk("rst_ready", 32'(o_READY), 1);
        chk("rst_count", 32'(o_COUNT), 0);
        chk("rst_data",  32'(o_DATA),  0);
        rst_n = 1'b1;

        // 1: asynchronous reset with three entries held
        send(11'd100); send(11'd101); send(11'd102);
        chk("pre_rst_count", 32'(o_COUNT), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_VALID), 0);
        chk("mid_rst_count", 32'(o_COUNT), 0);
        chk("mid_rst_ready", 32'(o_READY), 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2: single pass, visible one edge after push, no bypass
        i_READY = 1'b1;
        send(11'd15);
        chk("single_valid", 32'(o_VALID), 1);
        chk("single_data",  32'(o_DATA),  15);
        @(posedge clk);
        #1;
        chk("single_empty", 32'(o_VALID), 0);
        chk("single_count", 32'(o_COUNT), 0);

        // 3: burst order with consumer stalled
        i_READY = 1'b0;
        for (int i = 0; i < 5; i++) send(burst[i]);
        chk("burst_count", 32'(o_COUNT), 5);
        chk("burst_head",  32'(o_DATA),  15);
        drain();
        chk("burst_count_end", 32'(o_COUNT), 0);

        // 4: fill to DEPTH, ninth word waits for the first pop
        i_READY = 1'b0;
        for (int i = 1; i <= 8; i++) send(DW'(i));
        chk("full_ready", 32'(o_READY), 0);
        chk("full_count", 32'(o_COUNT), 8);
        i_VALID = 1'b1;
        i_DATA  = 11'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("full_hold_ready", 32'(o_READY), 0);
        chk("full_hold_count", 32'(o_COUNT), 8);
        i_READY = 1'b1;
        @(posedge clk);
        #1;
        i_READY = 1'b0;
        chk("full_pop_count", 32'(o_COUNT), 7);
        chk("full_pop_ready", 32'(o_READY), 1);
        @(posedge clk);
        sb.push_back(11'd9);
        #1;
        i_VALID = 1'b0;
        chk("full_refill_count", 32'(o_COUNT), 8);
        drain();

        // 5: concurrent push/pop at count 4
        i_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(DW'(20 + i));
        i_READY = 1'b1;
        i_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_DATA = DW'(40 + k);
            @(posedge clk);
            sb.push_back(DW'(40 + k));
            #1;
            chk("conc_count", 32'(o_COUNT), 4);
        end
        i_VALID = 1'b0;
        drain();

        // 6: wrap with random stalls on both sides
        prod_done = 0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(DW'(300 + 7 * i));
                end
                prod_done = 1;
            end
            begin
                for (int n = 0; n < 2000 && !prod_done; n++) begin
                    @(posedge clk);
                    #1;
                    i_READY = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        chk("wrap_count_end", 32'(o_COUNT), 0);
        chk("wrap_sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
